// File: rtl/pcm_fifo_sched.sv
// rtl/pcm_fifo_sched.sv - PCM FIFO write arbiter, FIFO reset sequencer, sample timer, AFLOW irq
// Optional DMA write path enabled by defining PCM_SCHED_DMA_EN.
module pcm_fifo_sched #(
  parameter int CLK_DIV    = 512,
  parameter int DIV_W      = 10,
  parameter int RST_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_wrdata,
  input  logic       dma_req,
  input  logic [7:0] dma_wrdata,
  output logic       dma_ack,
  input  logic       ctrl_fifo_reset,
  input  logic       irq_en,
  input  logic       irq_ack,
  input  logic       ovf_clr,
  input  logic       fifo_full,
  input  logic       fifo_almost_empty,
  output logic       fifo_write,
  output logic [7:0] fifo_wrdata,
  output logic       fifo_reset,
  output logic       next_sample,
  output logic       irq_aflow,
  output logic       overflow
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic [RC_W-1:0]  rst_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             ae_prev;
  logic             busy;
  logic             cpu_go;
  logic             cpu_drop;
  logic             dma_go;

  // CPU always wins; a write landing during a FIFO reset is discarded without flagging overflow.
  always_comb begin
    busy     = fifo_reset | ctrl_fifo_reset;
    cpu_go   = !rst && !busy && cpu_wr && !fifo_full;
    cpu_drop = !rst && !busy && cpu_wr && fifo_full;
`ifdef PCM_SCHED_DMA_EN
    dma_go      = !rst && !busy && !cpu_wr && dma_req && !fifo_full;
    fifo_wrdata = dma_go ? dma_wrdata : cpu_wrdata;
`else
    dma_go      = 1'b0;
    fifo_wrdata = cpu_wrdata;
`endif
    fifo_write = cpu_go | dma_go;
    dma_ack    = dma_go;
  end

`ifndef PCM_SCHED_DMA_EN
  logic dma_unused;
  assign dma_unused = ^{dma_req, dma_wrdata};
`endif

  // rst_cnt holds the remaining cycles after the current one; a new request restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_reset <= 1'b0;
      rst_cnt    <= '0;
    end else if (ctrl_fifo_reset) begin
      fifo_reset <= 1'b1;
      rst_cnt    <= RC_W'(RST_CYCLES - 1);
    end else if (fifo_reset) begin
      if (rst_cnt == '0) fifo_reset <= 1'b0;
      else               rst_cnt    <= rst_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= DIV_W'(CLK_DIV - 1);
      next_sample <= 1'b0;
    end else if (div_cnt == '0) begin
      div_cnt     <= DIV_W'(CLK_DIV - 1);
      next_sample <= 1'b1;
    end else begin
      div_cnt     <= div_cnt - 1'b1;
      next_sample <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           overflow <= 1'b0;
    else if (cpu_drop) overflow <= 1'b1;
    else if (ovf_clr)  overflow <= 1'b0;
  end

  // ae_prev resets high so an almost-empty level already present at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ae_prev   <= 1'b1;
      irq_aflow <= 1'b0;
    end else begin
      ae_prev <= fifo_almost_empty;
      if (!irq_en)                                irq_aflow <= 1'b0;
      else if (fifo_almost_empty && !ae_prev)     irq_aflow <= 1'b1;
      else if (irq_ack)                           irq_aflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcm_fifo_sched.sv
// tb/tb_pcm_fifo_sched.sv - self-checking bench for pcm_fifo_sched
// Expectations follow PCM_SCHED_DMA_EN when it is defined for the build.
module tb_pcm_fifo_sched;

`ifdef PCM_SCHED_DMA_EN
  localparam logic DMA_EN = 1'b1;
`else
  localparam logic DMA_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, cpu_wr, dma_req, dma_ack, ctrl_fifo_reset, irq_en, irq_ack, ovf_clr;
  logic fifo_full, fifo_almost_empty, fifo_write, fifo_reset, next_sample, irq_aflow, overflow;
  logic [7:0] cpu_wrdata, dma_wrdata, fifo_wrdata;

  pcm_fifo_sched #(.CLK_DIV(4), .DIV_W(2), .RST_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_wrdata(cpu_wrdata),
    .dma_req(dma_req), .dma_wrdata(dma_wrdata), .dma_ack(dma_ack),
    .ctrl_fifo_reset(ctrl_fifo_reset), .irq_en(irq_en), .irq_ack(irq_ack),
    .ovf_clr(ovf_clr), .fifo_full(fifo_full), .fifo_almost_empty(fifo_almost_empty),
    .fifo_write(fifo_write), .fifo_wrdata(fifo_wrdata), .fifo_reset(fifo_reset),
    .next_sample(next_sample), .irq_aflow(irq_aflow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cw;
    logic [7:0] cd;
    logic       dr;
    logic [7:0] dd;
    logic       full;
    logic       ew;
    logic [7:0] ed;
    logic       ea;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] sb[$];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic cw, input logic [7:0] cd, input logic dr,
                       input logic [7:0] dd, input logic full);
    cpu_wr = cw; cpu_wrdata = cd; dma_req = dr; dma_wrdata = dd; fifo_full = full;
  endtask

  // Push the expected write, then at mid-cycle check the strobe and pop against any write seen.
  task automatic tick(input string nm, input logic ew, input logic [7:0] ed, input logic ea);
    logic [7:0] e;
    if (ew) sb.push_back(ed);
    @(negedge clk);
    chk({nm, " fifo_write"}, fifo_write, ew);
    chk({nm, " dma_ack"}, dma_ack, ea);
    if (fifo_write) begin
      if (sb.size() == 0) chk({nm, " unexpected write"}, 1, 0);
      else begin
        e = sb.pop_front();
        chk({nm, " fifo_wrdata"}, fifo_wrdata, e);
      end
    end else if (ew) sb.delete();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h5A, 1'b1, 8'h33, 1'b0, 1'b1,   8'h5A, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b0, DMA_EN, 8'h33, DMA_EN};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h44, 1'b1, 1'b0,   8'h00, 1'b0};
    vecs[3] = '{1'b1, 8'hC3, 1'b0, 8'h00, 1'b0, 1'b1,   8'hC3, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h66, 1'b0, DMA_EN, 8'h66, DMA_EN};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0,   8'h00, 1'b0};

    rst = 1'b1; ctrl_fifo_reset = 1'b0; irq_ack = 1'b0; ovf_clr = 1'b0;
    irq_en = 1'b1; fifo_almost_empty = 1'b1;
    drive(1'b1, 8'hEE, 1'b1, 8'hDD, 1'b0);
    @(posedge clk); #1;
    tick("in_reset", 1'b0, 8'h00, 1'b0);
    adv();
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Cycle 0 is the first cycle with rst low; strobes expected on cycles 4, 8, 12.
    for (int k = 0; k < 14; k++) begin
      tick("timer", 1'b0, 8'h00, 1'b0);
      chk($sformatf("next_sample c%0d", k), next_sample, (k > 0 && k % 4 == 0));
      chk($sformatf("irq_held_ae c%0d", k), irq_aflow, 1'b0);
      if (k == 0) begin
        chk("rst fifo_reset", fifo_reset, 1'b0);
        chk("rst overflow", overflow, 1'b0);
      end
      adv();
    end
    fifo_almost_empty = 1'b0;

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].cw, vecs[i].cd, vecs[i].dr, vecs[i].dd, vecs[i].full);
      tick($sformatf("vec%0d", i), vecs[i].ew, vecs[i].ed, vecs[i].ea);
      adv();
    end
    chk("vec overflow", overflow, 1'b0);

    drive(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
    tick("ovf drop", 1'b0, 8'h00, 1'b0);
    adv();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick("ovf idle", 1'b0, 8'h00, 1'b0);
    chk("overflow set", overflow, 1'b1);
    adv();
    drive(1'b1, 8'h78, 1'b0, 8'h00, 1'b1); ovf_clr = 1'b1;
    tick("ovf clr+set", 1'b0, 8'h00, 1'b0);
    adv();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick("ovf clr", 1'b0, 8'h00, 1'b0);
    chk("overflow set wins", overflow, 1'b1);
    adv();
    ovf_clr = 1'b0;
    tick("ovf after", 1'b0, 8'h00, 1'b0);
    chk("overflow cleared", overflow, 1'b0);
    adv();

    ctrl_fifo_reset = 1'b1; drive(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0);
    tick("frst req", 1'b0, 8'h00, 1'b0);
    chk("fifo_reset c0", fifo_reset, 1'b0);
    adv();
    ctrl_fifo_reset = 1'b0; drive(1'b0, 8'h00, 1'b1, 8'hBB, 1'b0);
    tick("frst c1", 1'b0, 8'h00, 1'b0);
    chk("fifo_reset c1", fifo_reset, 1'b1);
    adv();
    drive(1'b1, 8'hAB, 1'b1, 8'hBB, 1'b1);
    tick("frst c2", 1'b0, 8'h00, 1'b0);
    chk("fifo_reset c2", fifo_reset, 1'b1);
    adv();
    drive(1'b0, 8'h00, 1'b1, 8'hBC, 1'b0);
    tick("frst c3", DMA_EN, 8'hBC, DMA_EN);
    chk("fifo_reset c3", fifo_reset, 1'b0);
    chk("frst overflow", overflow, 1'b0);
    adv();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    adv();

    fifo_almost_empty = 1'b1;
    tick("irq edge", 1'b0, 8'h00, 1'b0);
    chk("irq c0", irq_aflow, 1'b0);
    adv();
    irq_ack = 1'b1;
    tick("irq set", 1'b0, 8'h00, 1'b0);
    chk("irq fired", irq_aflow, 1'b1);
    adv();
    irq_ack = 1'b0;
    tick("irq acked", 1'b0, 8'h00, 1'b0);
    chk("irq ack clears", irq_aflow, 1'b0);
    adv();
    fifo_almost_empty = 1'b0;
    tick("irq level", 1'b0, 8'h00, 1'b0);
    chk("irq no refire", irq_aflow, 1'b0);
    adv();
    fifo_almost_empty = 1'b1; irq_ack = 1'b1;
    tick("irq set+ack", 1'b0, 8'h00, 1'b0);
    adv();
    irq_ack = 1'b0; irq_en = 1'b0;
    tick("irq refire", 1'b0, 8'h00, 1'b0);
    chk("irq set beats ack", irq_aflow, 1'b1);
    adv();
    tick("irq disabled", 1'b0, 8'h00, 1'b0);
    chk("irq_en clears", irq_aflow, 1'b0);
    adv();

    drive(1'b0, 8'h00, 1'b1, 8'h5C, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick($sformatf("dma hold %0d", k), DMA_EN, 8'h5C, DMA_EN);
      adv();
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    chk("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcm_fifo_sched.md
Name: pcm_fifo_sched

Overview:
Front-end controller for the PCM audio FIFO write port and sample timing. Arbitrates FIFO writes between the CPU data register and a streaming requester (DMA), and sequences register-initiated FIFO resets. Generates the periodic next_sample strobe consumed by the PCM block. Raises a latched AFLOW interrupt when the FIFO falls to almost-empty.

Parameters:
CLK_DIV, 512, clk cycles between next_sample strobes (>=2)
DIV_W, 10, counter width; must hold CLK_DIV-1
RST_CYCLES, 2, cycles fifo_reset is held per reset request (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpu_wr  in  1  CPU write strobe to FIFO data register; never asserted two consecutive cycles
cpu_wrdata  in  8  CPU write byte
dma_req  in  1  DMA write request; held with data until dma_ack
dma_wrdata  in  8  DMA write byte
dma_ack  out  1  DMA byte accepted this cycle (combinational)
ctrl_fifo_reset  in  1  one-cycle FIFO reset request from register file
irq_en  in  1  AFLOW interrupt enable
irq_ack  in  1  clear AFLOW pending
ovf_clr  in  1  clear overflow flag
fifo_full  in  1  from PCM FIFO; reflects writes up to previous cycle
fifo_almost_empty  in  1  from PCM FIFO
fifo_write  out  1  FIFO write strobe (combinational)
fifo_wrdata  out  8  FIFO write byte (combinational)
fifo_reset  out  1  FIFO reset (registered)
next_sample  out  1  one-cycle sample tick (registered)
irq_aflow  out  1  AFLOW interrupt pending (registered)
overflow  out  1  sticky: CPU write dropped on full (registered)

Behaviour:
- Reset (rst=1 at edge): fifo_reset=0, rst_cnt=0, next_sample=0, div_cnt=CLK_DIV-1, irq_aflow=0, ae_prev=1, overflow=0. Combinational outputs follow rules below; while rst=1 fifo_write=0, dma_ack=0.
- Reset sequencer: ctrl_fifo_reset -> next cycle fifo_reset=1 for exactly RST_CYCLES cycles. New request while active restarts the count. "busy" = fifo_reset=1 or ctrl_fifo_reset=1.
- Arbitration (per cycle, combinational on current inputs):
  - busy: fifo_write=0, dma_ack=0; CPU byte discarded silently (no overflow).
  - cpu_wr & !fifo_full: fifo_write=1, fifo_wrdata=cpu_wrdata, dma_ack=0 (CPU has absolute priority; never stalled).
  - cpu_wr & fifo_full: fifo_write=0, byte dropped, overflow set next edge.
  - !cpu_wr & dma_req & !fifo_full: fifo_write=1, fifo_wrdata=dma_wrdata, dma_ack=1.
  - else: fifo_write=0, fifo_wrdata=cpu_wrdata (don't-care), dma_ack=0.
  - DMA never sees ack when full; req held across any number of stall cycles.
- overflow: set wins over ovf_clr in the same cycle.
- Sample timer: free-running down-counter; at div_cnt==0 next cycle next_sample=1 and div_cnt reloads CLK_DIV-1; period exactly CLK_DIV cycles; first strobe CLK_DIV cycles after rst release. Unaffected by FIFO reset.
- AFLOW: ae_prev<=fifo_almost_empty each cycle. Set irq_aflow when irq_en & fifo_almost_empty & !ae_prev. irq_ack clears; simultaneous set and ack -> stays 1. irq_en=0 clears irq_aflow and blocks set. Almost-empty held high at rst release does not fire (ae_prev resets to 1).

Optional Feature:
PCM_SCHED_DMA_EN: defined -> DMA arbitration as above. Undefined -> dma_req/dma_wrdata ignored, dma_ack tied 0, mux reduces to CPU path only; all other behaviour identical.

Test Plan:
- CLK_DIV=4, release rst at cycle 0 -> next_sample high on cycles 4,8,12; never two consecutive.
- fifo_full=0, cpu_wr=1 data 0x5A while dma_req=1 data 0x33 -> fifo_write=1, wrdata 0x5A, dma_ack=0; next cycle (cpu_wr=0) wrdata 0x33, dma_ack=1.
- fifo_full=1, cpu_wr=1 -> fifo_write=0, overflow=1 next cycle; ovf_clr with another full cpu_wr same cycle -> overflow stays 1.
- ctrl_fifo_reset pulse, RST_CYCLES=2 -> fifo_reset high exactly 2 cycles; cpu_wr and dma_req during those cycles -> fifo_write=0, dma_ack=0, overflow unchanged.
- irq_en=1, fifo_almost_empty 0->1 -> irq_aflow=1 next cycle; irq_ack -> 0; almost_empty staying 1 -> no re-fire; 1->0->1 -> fires again.
- Build without PCM_SCHED_DMA_EN, dma_req=1 held 20 cycles, FIFO not full -> dma_ack=0, fifo_write=0 throughout.
